// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    // Frame header is a big-endian 16-bit word count
    localparam int HDR_BYTES = 2;

    // Number of host bytes making up one memory word
    function automatic int bytes_per_word(input int n);
        return n / 8;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Shifts host bytes MSB-first into an N-bit word and flags a completed word.
// Latency: word_full rises the cycle after the last byte of a word is shifted in, for one cycle.
// Backpressure: none; shifts only when shift_en is asserted by the owner FSM.
module word_assembler
    import loader_pkg::*;
#(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         shift_en,
    input  logic [7:0]   byte_in,
    output logic [N-1:0] word,
    output logic         last_byte,
    output logic         word_full
);

    localparam int BPW = bytes_per_word(N);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] cnt;

    // The byte about to be shifted completes the word
    assign last_byte = (cnt == CW'(BPW - 1));

    // Shift register, byte counter and one-cycle completion flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word      <= '0;
            cnt       <= '0;
            word_full <= 1'b0;
        end else if (clear) begin
            word      <= '0;
            cnt       <= '0;
            word_full <= 1'b0;
        end else begin
            word_full <= shift_en && last_byte;
            if (shift_en) begin
                word <= (word << 8) | N'(byte_in);
                cnt  <= last_byte ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Frames a host byte stream into N-bit words, writes them to program memory and releases the CPU on a good checksum.
// Latency: byte_ready one cycle after start; mem_we one cycle after a word's last byte; done/error one cycle after the checksum byte.
// Backpressure: byte_ready drops for the single WRITE cycle of each word and whenever no load is in progress.
module program_loader
    import loader_pkg::*;
#(
    parameter int          N         = 24,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic         mem_we,
    output logic [N-1:0] mem_address,
    output logic [N-1:0] mem_wdata,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         cpu_hold
);

    localparam int CNT_W = 8 * HDR_BYTES;

    loader_state_t    state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] word_idx_inc;
    logic [7:0]       csum;
    logic             xfer;
    logic             start_ok;
    logic             last_byte;
    logic             byte_ready_nxt, busy_nxt, done_nxt, error_nxt, cpu_hold_nxt;

    assign xfer         = byte_valid && byte_ready;
    assign start_ok     = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign word_idx_inc = word_idx + CNT_W'(1);

    // The assembler's registered word and completion flag drive the memory write port directly
    word_assembler #(.N(N)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .shift_en  ((state == ST_DATA) && xfer),
        .byte_in   (byte_in),
        .word      (mem_wdata),
        .last_byte (last_byte),
        .word_full (mem_we)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start_ok) state_nxt = ST_LEN_HI;
            ST_LEN_HI: if (xfer) state_nxt = ST_LEN_LO;
            ST_LEN_LO: if (xfer) state_nxt = ({count[7:0], byte_in} == '0) ? ST_CHECK : ST_DATA;
            ST_DATA:   if (xfer && last_byte) state_nxt = ST_WRITE;
            ST_WRITE:  state_nxt = (word_idx_inc == count) ? ST_CHECK : ST_DATA;
            ST_CHECK:  if (xfer) state_nxt = (byte_in == csum) ? ST_DONE : ST_ERROR;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered
    always_comb begin
        byte_ready_nxt = (state_nxt == ST_LEN_HI) || (state_nxt == ST_LEN_LO) ||
                         (state_nxt == ST_DATA)   || (state_nxt == ST_CHECK);
        busy_nxt       = !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE) || (state_nxt == ST_ERROR));
        done_nxt       = (state_nxt == ST_DONE);
        error_nxt      = (state_nxt == ST_ERROR);
        cpu_hold_nxt   = (state_nxt != ST_DONE);
    end

    // Registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            byte_ready <= byte_ready_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            cpu_hold   <= cpu_hold_nxt;
        end
    end

    // Header capture, word index, running checksum and write address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            word_idx    <= '0;
            csum        <= '0;
            mem_address <= '0;
        end else begin
            // word_idx only moves at the end of WRITE, so the address is already settled during WRITE
            mem_address <= N'(BASE_ADDR) + N'(word_idx);
            if (start_ok) begin
                count    <= '0;
                word_idx <= '0;
                csum     <= '0;
            end else begin
                if ((state == ST_LEN_HI || state == ST_LEN_LO) && xfer)
                    count <= {count[CNT_W-9:0], byte_in};
                if (state == ST_DATA && xfer)
                    csum <= csum ^ byte_in;
                if (state == ST_WRITE)
                    word_idx <= word_idx_inc;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a frame-level model and a per-cycle output checker.
// Latency: n/a.
// Backpressure: host driver holds each byte until byte_ready, with optional random idle gaps.
module tb_program_loader;

    localparam int N = 24;

    typedef struct {
        logic [N-1:0] addr;
        logic [N-1:0] data;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   byte_in = 8'h00;
    logic         byte_valid = 1'b0;
    logic         byte_ready, mem_we, busy, done, error, cpu_hold;
    logic [N-1:0] mem_address, mem_wdata;

    int errors = 0;
    int checks = 0;

    wr_t          exp_q[$];
    logic [7:0]   fr_data[$];
    logic [N-1:0] log_addr[$];
    logic [N-1:0] log_data[$];

    program_loader #(.N(N), .BASE_ADDR(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cpu_hold    (cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle checker: status invariants and every memory write against the model queue
    always @(negedge clk) begin
        if (!rst) begin
            chk("hold_is_not_done", cpu_hold, !done);
            if (busy) begin
                chk("ready_low_only_in_write", byte_ready, !mem_we);
                chk("no_error_while_busy", error, 1'b0);
            end else begin
                chk("idle_ready", byte_ready, 1'b0);
                chk("idle_we", mem_we, 1'b0);
            end
            if (mem_we) begin
                log_addr.push_back(mem_address);
                log_data.push_back(mem_wdata);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    chk("wr_addr", mem_address, exp_q[0].addr);
                    chk("wr_data", mem_wdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int max_gap);
        int g;
        int t;
        g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (g) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_in    = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte_ready got 0 expected 1");
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ready_latency", byte_ready, 1'b1);
        chk("start_busy", busy, 1'b1);
        chk("start_hold", cpu_hold, 1'b1);
        chk("start_clears_done", done, 1'b0);
        chk("start_clears_error", error, 1'b0);
    endtask

    // Sends fr_data as a full frame; model derives writes and verdict from the frame rules
    task automatic load_frame(input logic [7:0] csum_byte, input int max_gap, input bit skip_start);
        int          nw;
        logic [15:0] cnt;
        logic [7:0]  x;
        logic [N-1:0] w;
        bit          ok;
        nw  = fr_data.size() / (N / 8);
        cnt = 16'(nw);
        x   = 8'h00;
        if (!skip_start) do_start();
        send(cnt[15:8], max_gap);
        send(cnt[7:0], max_gap);
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int b = 0; b < N / 8; b++) begin
                w = (w << 8) | N'(fr_data[i * (N / 8) + b]);
                x = x ^ fr_data[i * (N / 8) + b];
                if (b == N / 8 - 1) exp_q.push_back('{addr: N'(i), data: w});
                send(fr_data[i * (N / 8) + b], max_gap);
            end
            chk("we_latency", mem_we, 1'b1);
        end
        send(csum_byte, max_gap);
        ok = (x == csum_byte);
        chk("frame_done", done, ok);
        chk("frame_error", error, !ok);
        chk("frame_hold", cpu_hold, !ok);
        chk("frame_not_busy", busy, 1'b0);
        chk("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_byte_ready", byte_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_cpu_hold", cpu_hold, 1'b1);
        rst = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        chk("nostart_ready", byte_ready, 1'b0);
        chk("nostart_busy", busy, 1'b0);
        chk("nostart_no_writes", log_data.size(), 0);

        // Two-word load
        fr_data = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        load_frame(8'hF9, 0, 1'b0);
        chk("two_word_count", log_data.size(), 2);
        chk("two_word_a0", log_addr[0], 24'h000000);
        chk("two_word_d0", log_data[0], 24'h123456);
        chk("two_word_a1", log_addr[1], 24'h000001);
        chk("two_word_d1", log_data[1], 24'hABCDEF);
        chk("two_word_done_lit", done, 1'b1);

        // Bad checksum, then a fresh start clears error
        load_frame(8'h00, 0, 1'b0);
        chk("bad_cksum_writes", log_data.size(), 4);
        chk("bad_cksum_d3", log_data[3], 24'hABCDEF);
        chk("bad_cksum_error_lit", error, 1'b1);
        chk("bad_cksum_hold_lit", cpu_hold, 1'b1);
        do_start();

        // Zero-length frame continues from the start above
        fr_data = {};
        load_frame(8'h00, 0, 1'b1);
        chk("zero_len_no_writes", log_data.size(), 4);
        chk("zero_len_done_lit", done, 1'b1);

        // Two-word load with random idle gaps
        fr_data = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        load_frame(8'hF9, 3, 1'b0);
        chk("gap_count", log_data.size(), 6);
        chk("gap_d0", log_data[4], 24'h123456);
        chk("gap_d1", log_data[5], 24'hABCDEF);

        // Reset mid-frame, then a clean one-word load
        do_start();
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h12, 0);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", byte_ready, 1'b0);
        chk("midrst_hold", cpu_hold, 1'b1);
        chk("midrst_we", mem_we, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_writes", log_data.size(), 6);
        fr_data = '{8'hAA, 8'hBB, 8'hCC};
        load_frame(8'hDD, 0, 1'b0);
        chk("recover_count", log_data.size(), 7);
        chk("recover_addr", log_addr[6], 24'h000000);
        chk("recover_data", log_data[6], 24'hAABBCC);
        chk("recover_done_lit", done, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
